// File: rtl/mult_unit_if.sv
// Bus between the core and the sequential multiplier: launch request,
// operands, status and the HI/LO result, plus a debug view of the FSM.
interface mult_unit_if #(
    parameter int n = 32
);
    logic [2:0]   alucontrol;
    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         busy;
    logic         done;
    logic [n-1:0] hi;
    logic [n-1:0] lo;
    logic [1:0]   state;

    // Handshake: a request is accepted on a rising edge where start is high,
    // alucontrol is 3'b011 and busy is low; anything else is dropped, not
    // queued. done pulses for one cycle once hi/lo hold the new product.
    modport master (
        output alucontrol, start, a, b,
        input  busy, done, hi, lo, state
    );

    modport slave (
        input  alucontrol, start, a, b,
        output busy, done, hi, lo, state
    );
endinterface

// File: rtl/mult_unit.sv
// Sequential signed multiplier for the mult instruction: magnitudes are
// multiplied by a radix-2 shift-add loop over n cycles, then the sign is
// applied in one extra cycle and the result lands in HI/LO.
module mult_unit #(
    parameter int n = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_unit_if.slave    bus
);
    localparam int CW = $clog2(n) + 1;
    localparam logic [2:0] MULT_CODE = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t         state;
    logic [2*n-1:0] mcand;
    logic [n-1:0]   mplier;
    logic [2*n-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           busy_r;
    logic           done_r;
    logic [n-1:0]   hi_r;
    logic [n-1:0]   lo_r;

    logic           launch;
    logic [n-1:0]   mag_a;
    logic [n-1:0]   mag_b;

    // Operand magnitudes as unsigned n-bit values; the most negative value
    // maps onto itself, which is exactly 2^(n-1) when read unsigned.
    always_comb begin
        launch = bus.start && (bus.alucontrol == MULT_CODE);
        mag_a  = bus.a[n-1] ? -bus.a : bus.a;
        mag_b  = bus.b[n-1] ? -bus.b : bus.b;
    end

    // Control FSM and datapath: capture, n shift-add steps, sign fix-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (launch) begin
                        mcand  <= {{n{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= bus.a[n-1] ^ bus.b[n-1];
                        acc    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(n - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    {hi_r, lo_r} <= neg ? -acc : acc;
                    done_r       <= 1'b1;
                    busy_r       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.state = state;
endmodule
